mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single backing-memory port between the instruction cache refill path and the data cache read and write paths. It issues one memory transaction at a time and holds address, data and direction stable until the memory acknowledges. It then returns the result to the owning requester with a one-cycle valid pulse. It sits between `icache`/`dcache` and `mem`, replacing the separate per-cache memory ports with one shared port.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `STARVE_MAX`, 4, consecutive data grants allowed while `i_req` is pending
- `TIMEOUT`, 64, cycles to wait for `m_val` before aborting

Ports:
- `clk`  in  1  clock; all state updates on the posedge
- `reset`  in  1  synchronous, active-high
- `i_req`  in  1  icache read request; held high until `i_val`
- `i_adr`  in  AW  icache read address
- `i_rdata`  out  DW  icache read data; valid with `i_val`
- `i_val`  out  1  one-cycle completion pulse to icache
- `dr_req`  in  1  dcache read request
- `dr_adr`  in  AW  dcache read address
- `dr_rdata`  out  DW  dcache read data
- `dr_val`  out  1  dcache read completion pulse
- `dw_req`  in  1  dcache write request
- `dw_adr`  in  AW  dcache write address
- `dw_wdata`  in  DW  dcache write data
- `dw_val`  out  1  dcache write completion pulse
- `m_req`  out  1  memory request
- `m_we`  out  1  1 = write
- `m_adr`  out  AW  memory address
- `m_wdata`  out  DW  memory write data
- `m_rdata`  in  DW  memory read data; sampled when `m_val` is high
- `m_val`  in  1  memory acknowledge
- `bus_err`  out  1  one-cycle pulse, coincident with the owner's val, when the transaction timed out

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:** if any request is high, pick the owner, latch its address and write data, and go to WAIT. Otherwise stay in IDLE.
- **Priority:** `dw` > `dr` > `i`.
  - Exception: if `i_req` is high and `starve_cnt == STARVE_MAX`, `i` wins.
- **`starve_cnt` (3 bits, saturating):**
  - Increments on each `dw`/`dr` grant made while `i_req` is high.
  - Clears on an `i` grant.
  - Clears on any grant made while `i_req` is low.
- **WAIT:**
  - `m_req` = 1. `m_we` = 1 only when the owner is `dw`. `m_adr` and `m_wdata` come from the latched values and stay stable.
  - `tmo_cnt` increments every cycle.
  - On `m_val`: latch `m_rdata` and go to RESP.
  - When `tmo_cnt == TIMEOUT-1` without `m_val`: set the error flag, force the read data to 0, and go to RESP.
- **RESP:**
  - Pulse exactly one of `i_val`, `dr_val`, `dw_val` according to the owner.
  - Drive `bus_err` from the error flag.
  - Go to IDLE.
- Read-data outputs hold their last value until the next RESP for the same owner.
- Requests are sampled only in IDLE. A requester dropping `req` during WAIT does not cancel the transaction; its val still pulses.
- Simultaneous `dw` and `dr` to the same address: the write goes first, so the read returns the new data.

## Timing
- **Reset (synchronous):**
  - State → IDLE.
  - `m_req`, `m_we`, `i_val`, `dr_val`, `dw_val`, `bus_err` = 0.
  - `m_adr`, `m_wdata`, `i_rdata`, `dr_rdata`, `starve_cnt`, `tmo_cnt` = 0.
  - A reset during WAIT abandons the transaction. No val is pulsed.
- **Cycle numbering:**
  - Cycle 0: IDLE sees the request.
  - Cycle 1: `m_req` high.
  - Cycle k ≥ 1: `m_val` arrives.
  - Cycle k+1: RESP, val pulse.
  - Cycle k+2: IDLE, next arbitration.
- Minimum request-to-val latency is 2 cycles, when `m_val` arrives at cycle 1. Back-to-back grants are spaced 3 cycles apart minimum.
- `m_val` arriving while `m_req` = 0 is ignored.
- Timeout: `m_req` stays high for exactly `TIMEOUT` cycles, then RESP follows.

## Structure
- `mem_arb_pkg` holds:
  - `state_t` (IDLE, WAIT, RESP).
  - `owner_t` (OWN_I, OWN_DR, OWN_DW).
  - Default `STARVE_MAX` / `TIMEOUT` constants.
- One combinational sub-module, `mem_arb_pick`: takes the three reqs and the starve flag, outputs a one-hot grant as `owner_t`.

## Test plan
- Single `i_req` at 0x100, memory acks on its first `m_req` cycle with 0xDEADBEEF → `m_req` high for 1 cycle with `m_we` = 0, `i_val` 2 cycles after the request, `i_rdata` = 0xDEADBEEF.
- `dw_req` (0x40, 0x12345678) and `dr_req` (0x40) both high in the same cycle, memory modelled as RAM → write is granted first with `m_we` = 1; then `dr_val` returns 0x12345678.
- `i_req` held high while `dr_req` is re-asserted immediately after every `dr_val` → exactly 4 data grants, then the `i` grant, then data resumes.
- Memory never acks, `TIMEOUT` = 64 → `m_req` high for exactly 64 cycles; then `dr_val` and `bus_err` pulse together with `dr_rdata` = 0.
- Reset asserted during WAIT → next cycle all outputs are 0 and the state is IDLE; no val is ever pulsed for the abandoned transaction.
- Requester drops `i_req` during WAIT → `i_val` still pulses once; no second transaction is issued.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default constants for the memory arbiter.
//   state_t : arbiter FSM states
//   owner_t : one-hot transaction owner (icache read, dcache read, dcache write)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OWN_I  = 3'b001,
        OWN_DR = 3'b010,
        OWN_DW = 3'b100
    } owner_t;

    localparam int STARVE_MAX_DEF = 4;
    localparam int TIMEOUT_DEF    = 64;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selection.
//   i_req, dr_req, dw_req : pending requests
//   starve                : icache has waited through the maximum data grants
//   grant                 : one-hot owner; only meaningful when some req is high
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   dr_req,
    input  logic   dw_req,
    input  logic   starve,
    output owner_t grant
);

    always_comb begin
        grant = OWN_I;
        if (i_req && starve)
            grant = OWN_I;
        else if (dw_req)
            grant = OWN_DW;    // write before read keeps same-address RAW ordering
        else if (dr_req)
            grant = OWN_DR;
        else
            grant = OWN_I;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backing-memory port between icache refill reads and
// dcache reads/writes. One transaction in flight; request fields are latched at
// grant and held on the memory port until m_val or timeout.
//   clk, reset           : clock, synchronous active-high reset
//   i_req/i_adr          : icache read request -> i_rdata, i_val
//   dr_req/dr_adr        : dcache read request -> dr_rdata, dr_val
//   dw_req/dw_adr/dw_wdata : dcache write request -> dw_val
//   m_req/m_we/m_adr/m_wdata : memory request, held while waiting
//   m_rdata/m_val        : memory read data / acknowledge
//   bus_err              : pulses with the owner's val when the access timed out
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_adr,
    output logic [DW-1:0] i_rdata,
    output logic          i_val,
    input  logic          dr_req,
    input  logic [AW-1:0] dr_adr,
    output logic [DW-1:0] dr_rdata,
    output logic          dr_val,
    input  logic          dw_req,
    input  logic [AW-1:0] dw_adr,
    input  logic [DW-1:0] dw_wdata,
    output logic          dw_val,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_adr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_val,
    output logic          bus_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_nxt;
    owner_t        owner, grant;
    logic [2:0]    starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          err;
    logic          any_req;
    logic          starve;
    logic          tmo_hit;

    assign any_req = i_req | dr_req | dw_req;
    assign starve  = (starve_cnt == 3'(STARVE_MAX));
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

    mem_arb_pick u_pick (
        .i_req  (i_req),
        .dr_req (dr_req),
        .dw_req (dw_req),
        .starve (starve),
        .grant  (grant)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        m_req     = 1'b0;
        m_we      = 1'b0;
        i_val     = 1'b0;
        dr_val    = 1'b0;
        dw_val    = 1'b0;
        bus_err   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req)
                    state_nxt = WAIT;
            end
            WAIT: begin
                m_req = 1'b1;
                m_we  = (owner == OWN_DW);
                if (m_val || tmo_hit)
                    state_nxt = RESP;
            end
            RESP: begin
                i_val     = (owner == OWN_I);
                dr_val    = (owner == OWN_DR);
                dw_val    = (owner == OWN_DW);
                bus_err   = err;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, starvation/timeout counters and read-data return.
    // Read data lands in the owner's output register on the WAIT exit so it is
    // already valid during the RESP val pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OWN_I;
            m_adr      <= '0;
            m_wdata    <= '0;
            i_rdata    <= '0;
            dr_rdata   <= '0;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (any_req) begin
                        owner   <= grant;
                        err     <= 1'b0;
                        m_wdata <= (grant == OWN_DW) ? dw_wdata : '0;
                        case (grant)
                            OWN_DW:  m_adr <= dw_adr;
                            OWN_DR:  m_adr <= dr_adr;
                            default: m_adr <= i_adr;
                        endcase
                        if (!i_req || grant == OWN_I)
                            starve_cnt <= '0;
                        else if (starve_cnt != 3'b111)
                            starve_cnt <= starve_cnt + 3'd1;
                    end
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (m_val) begin
                        if (owner == OWN_I)  i_rdata  <= m_rdata;
                        if (owner == OWN_DR) dr_rdata <= m_rdata;
                    end else if (tmo_hit) begin
                        err <= 1'b1;
                        if (owner == OWN_I)  i_rdata  <= '0;
                        if (owner == OWN_DR) dr_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, dr_req, dw_req;
    logic [31:0] i_adr, dr_adr, dw_adr, dw_wdata;
    logic [31:0] i_rdata, dr_rdata;
    logic        i_val, dr_val, dw_val;
    logic        m_req, m_we;
    logic [31:0] m_adr, m_wdata, m_rdata;
    logic        m_val;
    logic        bus_err;

    mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_adr(i_adr), .i_rdata(i_rdata), .i_val(i_val),
        .dr_req(dr_req), .dr_adr(dr_adr), .dr_rdata(dr_rdata), .dr_val(dr_val),
        .dw_req(dw_req), .dw_adr(dw_adr), .dw_wdata(dw_wdata), .dw_val(dw_val),
        .m_req(m_req), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_val(m_val), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic err; } rsp_t;
    typedef struct { logic we; logic [31:0] adr; logic [31:0] wdata; } mtx_t;

    rsp_t iq[$], drq[$], dwq[$];
    mtx_t mq[$];
    logic [31:0] ram [logic [31:0]];

    int vectors = 0;
    int miscompares = 0;
    int ack_delay = 0;
    bit no_ack = 0;
    int last_len = 0;
    localparam int BOUND = 300;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void bad(string nm, string msg);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", nm, msg);
    endfunction

    // Memory model: acks after ack_delay m_req cycles (0 = first cycle).
    task automatic mem_model();
        int mlen = 0;
        mtx_t e, f;
        forever begin
            @(negedge clk);
            if (m_req) begin
                if (mlen == 0) begin
                    f.we = m_we; f.adr = m_adr; f.wdata = m_wdata;
                    if (mq.size() == 0) bad("mem_unexpected", $sformatf("request adr %0h", m_adr));
                    else begin
                        e = mq.pop_front();
                        chk("mem_we", {31'd0, m_we}, {31'd0, e.we});
                        chk("mem_adr", m_adr, e.adr);
                        if (e.we) chk("mem_wdata", m_wdata, e.wdata);
                    end
                end else begin
                    chk("mem_adr_stable", m_adr, f.adr);
                    chk("mem_we_stable", {31'd0, m_we}, {31'd0, f.we});
                end
                if (!no_ack && mlen == ack_delay) begin
                    m_val = 1'b1;
                    if (m_we) begin
                        ram[m_adr] = m_wdata;
                        m_rdata = 32'hBAD0_BAD0;
                    end else
                        m_rdata = ram.exists(m_adr) ? ram[m_adr] : 32'h0;
                end else begin
                    m_val = 1'b0;
                    m_rdata = 32'hBAD0_BAD0;
                end
                mlen++;
            end else begin
                if (mlen != 0) last_len = mlen;
                mlen = 0;
                m_val = 1'b0;
            end
        end
    endtask

    // Response monitor: pops the owner's expected queue on each val pulse.
    task automatic monitor();
        int nv;
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                nv = int'(i_val) + int'(dr_val) + int'(dw_val);
                if (nv > 1) bad("val_onehot", $sformatf("%0d vals high", nv));
                if (nv == 0 && bus_err) bad("bus_err_stray", "bus_err without val");
                if (i_val) begin
                    if (iq.size() == 0) bad("i_unexpected", "i_val with no request");
                    else begin
                        e = iq.pop_front();
                        chk("i_rdata", i_rdata, e.data);
                        chk("i_bus_err", {31'd0, bus_err}, {31'd0, e.err});
                    end
                end
                if (dr_val) begin
                    if (drq.size() == 0) bad("dr_unexpected", "dr_val with no request");
                    else begin
                        e = drq.pop_front();
                        chk("dr_rdata", dr_rdata, e.data);
                        chk("dr_bus_err", {31'd0, bus_err}, {31'd0, e.err});
                    end
                end
                if (dw_val) begin
                    if (dwq.size() == 0) bad("dw_unexpected", "dw_val with no request");
                    else begin
                        e = dwq.pop_front();
                        chk("dw_bus_err", {31'd0, bus_err}, {31'd0, e.err});
                    end
                end
            end
        end
    endtask

    // Requester drivers: called right after a negedge; return at the negedge
    // where the val is seen. lat counts cycles from request to val.
    task automatic run_i(input logic [31:0] adr, input int drop_at, output int lat);
        int n = 0;
        bit seen = 0;
        lat = -1;
        i_adr = adr; i_req = 1'b1;
        while (!seen && n < BOUND) begin
            @(negedge clk); n++;
            if (i_val) begin seen = 1; lat = n; end
            else if (drop_at > 0 && n >= drop_at) i_req = 1'b0;
        end
        i_req = 1'b0;
        if (!seen) bad("i_wait", "no i_val within bound");
    endtask

    task automatic run_dr(input logic [31:0] adr);
        int n = 0;
        bit seen = 0;
        dr_adr = adr; dr_req = 1'b1;
        while (!seen && n < BOUND) begin
            @(negedge clk); n++;
            if (dr_val) seen = 1;
        end
        dr_req = 1'b0;
        if (!seen) bad("dr_wait", "no dr_val within bound");
    endtask

    task automatic run_dw(input logic [31:0] adr, input logic [31:0] wd);
        int n = 0;
        bit seen = 0;
        dw_adr = adr; dw_wdata = wd; dw_req = 1'b1;
        while (!seen && n < BOUND) begin
            @(negedge clk); n++;
            if (dw_val) seen = 1;
        end
        dw_req = 1'b0;
        if (!seen) bad("dw_wait", "no dw_val within bound");
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_m_req"}, {31'd0, m_req}, 32'd0);
        chk({tag, "_m_we"}, {31'd0, m_we}, 32'd0);
        chk({tag, "_m_adr"}, m_adr, 32'd0);
        chk({tag, "_m_wdata"}, m_wdata, 32'd0);
        chk({tag, "_i_rdata"}, i_rdata, 32'd0);
        chk({tag, "_dr_rdata"}, dr_rdata, 32'd0);
        chk({tag, "_vals"}, {29'd0, i_val, dr_val, dw_val}, 32'd0);
        chk({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        i_req = 0; dr_req = 0; dw_req = 0;
        i_adr = 0; dr_adr = 0; dw_adr = 0; dw_wdata = 0;
        m_val = 0; m_rdata = 0;
        fork
            mem_model();
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation did not complete");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single icache read, ack on the first m_req cycle.
        ack_delay = 0;
        ram[32'h100] = 32'hDEADBEEF;
        mq.push_back('{we: 1'b0, adr: 32'h100, wdata: 32'h0});
        iq.push_back('{data: 32'hDEADBEEF, err: 1'b0});
        run_i(32'h100, 0, lat);
        chk("i_latency", lat, 32'd2);
        @(negedge clk);
        chk("i_mreq_len", last_len, 32'd1);

        // Same-address write and read together: write first, read sees new data.
        ack_delay = 1;
        ram[32'h40] = 32'h0BADF00D;
        mq.push_back('{we: 1'b1, adr: 32'h40, wdata: 32'h12345678});
        mq.push_back('{we: 1'b0, adr: 32'h40, wdata: 32'h0});
        dwq.push_back('{data: 32'h0, err: 1'b0});
        drq.push_back('{data: 32'h12345678, err: 1'b0});
        fork
            run_dw(32'h40, 32'h12345678);
            run_dr(32'h40);
        join
        @(negedge clk);

        // Starvation: four data grants, then icache, then data resumes.
        ack_delay = 2;
        ram[32'h200] = 32'h11112222;
        for (int k = 0; k < 6; k++) ram[32'h300 + 4*k] = 32'hA0000000 + k;
        for (int k = 0; k < 4; k++) mq.push_back('{we: 1'b0, adr: 32'h300 + 4*k, wdata: 32'h0});
        mq.push_back('{we: 1'b0, adr: 32'h200, wdata: 32'h0});
        for (int k = 4; k < 6; k++) mq.push_back('{we: 1'b0, adr: 32'h300 + 4*k, wdata: 32'h0});
        iq.push_back('{data: 32'h11112222, err: 1'b0});
        for (int k = 0; k < 6; k++) drq.push_back('{data: 32'hA0000000 + k, err: 1'b0});
        fork
            run_i(32'h200, 0, lat);
            for (int k = 0; k < 6; k++) run_dr(32'h300 + 4*k);
        join
        @(negedge clk);

        // Timeout: memory never acks.
        no_ack = 1;
        ram[32'h500] = 32'h55;
        mq.push_back('{we: 1'b0, adr: 32'h500, wdata: 32'h0});
        drq.push_back('{data: 32'h0, err: 1'b1});
        run_dr(32'h500);
        @(negedge clk);
        chk("tmo_mreq_len", last_len, 32'd64);
        no_ack = 0;

        // Reset during WAIT abandons the transaction.
        no_ack = 1;
        mq.push_back('{we: 1'b0, adr: 32'h600, wdata: 32'h0});
        i_adr = 32'h600; i_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_reset_m_req", {31'd0, m_req}, 32'd1);
        reset = 1'b1; i_req = 1'b0;
        @(negedge clk);
        chk_all_zero("wait_reset");
        reset = 1'b0; no_ack = 0;
        repeat (10) @(negedge clk);
        chk("post_reset_idle", {31'd0, m_req}, 32'd0);

        // Requester drops i_req during WAIT: one val, no second transaction.
        ack_delay = 3;
        ram[32'h700] = 32'hCAFE0007;
        mq.push_back('{we: 1'b0, adr: 32'h700, wdata: 32'h0});
        iq.push_back('{data: 32'hCAFE0007, err: 1'b0});
        run_i(32'h700, 1, lat);
        chk("drop_latency", lat, 32'd5);
        repeat (10) @(negedge clk);

        chk("iq_drained", iq.size(), 32'd0);
        chk("drq_drained", drq.size(), 32'd0);
        chk("dwq_drained", dwq.size(), 32'd0);
        chk("mq_drained", mq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
